// File: rtl/reservation_station.sv
// reservation_station: unified out-of-order reservation station.
// Holds renamed instructions until both sources are ready, wakes operands
// from the CDBs, and issues up to NUM_ALU_FUS ready entries per cycle into
// registered per-FU issue slots.
//
// Handshake: a dispatch transfer happens on a cycle where disp_ready_o is high
// and at least one disp_valid_i lane is high; disp_ready_o is all-or-nothing
// and never depends on disp_valid_i. Issue has no back-channel: an FU is only
// offered an entry on a cycle where it raised fu_ready_i, and issue_valid_o
// is a single-cycle strobe.
module reservation_station #(
  parameter int WORD_SIZE          = 32,
  parameter int NUM_P_REGS         = 64,
  parameter int ALU_OP_SIZE        = 4,
  parameter int CONTR_SIG_SIZE     = 5,
  parameter int CONTR_ALUSRC_INDEX = 2,
  parameter int NUM_RS_ROWS        = 16,
  parameter int DISPATCH_WIDTH     = 2,
  parameter int NUM_ALU_FUS        = 2,
  parameter int NUM_CDB            = 2,
  parameter int ROB_IDX_SIZE       = 6,
  localparam int TAG               = $clog2(NUM_P_REGS),
  localparam int CW                = $clog2(NUM_RS_ROWS + 1)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_n_i,
  input  logic                                     flush_i,
  input  logic [DISPATCH_WIDTH-1:0]                disp_valid_i,
  output logic                                     disp_ready_o,
  input  logic [DISPATCH_WIDTH*ALU_OP_SIZE-1:0]    disp_alu_op_i,
  input  logic [DISPATCH_WIDTH*CONTR_SIG_SIZE-1:0] disp_contr_i,
  input  logic [DISPATCH_WIDTH*TAG-1:0]            disp_dest_i,
  input  logic [DISPATCH_WIDTH*ROB_IDX_SIZE-1:0]   disp_rob_i,
  input  logic [DISPATCH_WIDTH*TAG-1:0]            disp_rs1_i,
  input  logic [DISPATCH_WIDTH*TAG-1:0]            disp_rs2_i,
  input  logic [DISPATCH_WIDTH*WORD_SIZE-1:0]      disp_rs1_val_i,
  input  logic [DISPATCH_WIDTH*WORD_SIZE-1:0]      disp_rs2_val_i,
  input  logic [DISPATCH_WIDTH-1:0]                disp_rs1_ready_i,
  input  logic [DISPATCH_WIDTH-1:0]                disp_rs2_ready_i,
  input  logic [DISPATCH_WIDTH*WORD_SIZE-1:0]      disp_imm_i,
  input  logic [NUM_CDB-1:0]                       cdb_valid_i,
  input  logic [NUM_CDB*TAG-1:0]                   cdb_tag_i,
  input  logic [NUM_CDB*WORD_SIZE-1:0]             cdb_data_i,
  input  logic [NUM_ALU_FUS-1:0]                   fu_ready_i,
  output logic [NUM_ALU_FUS-1:0]                   issue_valid_o,
  output logic [NUM_ALU_FUS*ALU_OP_SIZE-1:0]       issue_alu_op_o,
  output logic [NUM_ALU_FUS*CONTR_SIG_SIZE-1:0]    issue_contr_o,
  output logic [NUM_ALU_FUS*TAG-1:0]               issue_dest_o,
  output logic [NUM_ALU_FUS*ROB_IDX_SIZE-1:0]      issue_rob_o,
  output logic [NUM_ALU_FUS*WORD_SIZE-1:0]         issue_data0_o,
  output logic [NUM_ALU_FUS*WORD_SIZE-1:0]         issue_data1_o,
  output logic [CW-1:0]                            free_count_o
);

  localparam int RW = (NUM_RS_ROWS > 1) ? $clog2(NUM_RS_ROWS) : 1;

  // Entry storage; only used_q is reset, the payload is qualified by it.
  logic [NUM_RS_ROWS-1:0]    used_q;
  logic [CONTR_SIG_SIZE-1:0] contr_q   [NUM_RS_ROWS];
  logic [ALU_OP_SIZE-1:0]    alu_op_q  [NUM_RS_ROWS];
  logic [TAG-1:0]            dest_q    [NUM_RS_ROWS];
  logic [ROB_IDX_SIZE-1:0]   rob_q     [NUM_RS_ROWS];
  logic [TAG-1:0]            rs1_tag_q [NUM_RS_ROWS];
  logic [TAG-1:0]            rs2_tag_q [NUM_RS_ROWS];
  logic [WORD_SIZE-1:0]      rs1_val_q [NUM_RS_ROWS];
  logic [WORD_SIZE-1:0]      rs2_val_q [NUM_RS_ROWS];
  logic [WORD_SIZE-1:0]      imm_q     [NUM_RS_ROWS];
  logic [NUM_RS_ROWS-1:0]    rs1_rdy_q;
  logic [NUM_RS_ROWS-1:0]    rs2_rdy_q;

  logic [CW-1:0]             free_cnt;
  logic                      disp_fire;
  logic [NUM_RS_ROWS-1:0]    alloc_taken;
  logic [DISPATCH_WIDTH-1:0] alloc_valid;
  logic [RW-1:0]             alloc_row [DISPATCH_WIDTH];
  logic [WORD_SIZE:0]        byp1      [DISPATCH_WIDTH];
  logic [WORD_SIZE:0]        byp2      [DISPATCH_WIDTH];
  logic [WORD_SIZE:0]        wake1     [NUM_RS_ROWS];
  logic [WORD_SIZE:0]        wake2     [NUM_RS_ROWS];
  logic [NUM_RS_ROWS-1:0]    sel_taken;
  logic [NUM_ALU_FUS-1:0]    sel_valid;
  logic [RW-1:0]             sel_row   [NUM_ALU_FUS];

  // CDB match for one tag: {hit, data}. Scanned high to low so the lowest
  // CDB index wins when two buses carry the same tag.
  function automatic logic [WORD_SIZE:0] cdb_lookup(input logic [TAG-1:0] tag);
    logic [WORD_SIZE:0] res;
    res = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (cdb_valid_i[c] && (cdb_tag_i[c*TAG +: TAG] == tag))
        res = {1'b1, cdb_data_i[c*WORD_SIZE +: WORD_SIZE]};
    end
    return res;
  endfunction

  // Free-entry count derived from the registered use bits.
  always_comb begin
    free_cnt = '0;
    for (int r = 0; r < NUM_RS_ROWS; r++) begin
      if (!used_q[r]) free_cnt = free_cnt + CW'(1);
    end
  end

  assign free_count_o = free_cnt;
  assign disp_ready_o = rst_n_i && (free_cnt >= CW'(DISPATCH_WIDTH));
  assign disp_fire    = disp_ready_o && (|disp_valid_i) && !flush_i;

  // Allocation: each valid lane, in lane order, takes the lowest free row.
  always_comb begin
    alloc_taken = '0;
    alloc_valid = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) alloc_row[k] = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      if (disp_valid_i[k]) begin
        for (int r = 0; r < NUM_RS_ROWS; r++) begin
          if (!alloc_valid[k] && !used_q[r] && !alloc_taken[r]) begin
            alloc_valid[k] = 1'b1;
            alloc_row[k]   = RW'(r);
            alloc_taken[r] = 1'b1;
          end
        end
      end
    end
  end

  // CDB lookups for dispatch-time bypass and for stored-entry wakeup.
  always_comb begin
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      byp1[k] = cdb_lookup(disp_rs1_i[k*TAG +: TAG]);
      byp2[k] = cdb_lookup(disp_rs2_i[k*TAG +: TAG]);
    end
    for (int r = 0; r < NUM_RS_ROWS; r++) begin
      wake1[r] = cdb_lookup(rs1_tag_q[r]);
      wake2[r] = cdb_lookup(rs2_tag_q[r]);
    end
  end

  // Select: FUs in index order each take the lowest ready, untaken row.
  always_comb begin
    sel_taken = '0;
    sel_valid = '0;
    for (int f = 0; f < NUM_ALU_FUS; f++) sel_row[f] = '0;
    for (int f = 0; f < NUM_ALU_FUS; f++) begin
      if (fu_ready_i[f]) begin
        for (int r = 0; r < NUM_RS_ROWS; r++) begin
          if (!sel_valid[f] && !sel_taken[r] && used_q[r] &&
              rs1_rdy_q[r] && rs2_rdy_q[r]) begin
            sel_valid[f] = 1'b1;
            sel_row[f]   = RW'(r);
            sel_taken[r] = 1'b1;
          end
        end
      end
    end
  end

  // Use bits: flush/reset clear everything; issue frees, dispatch claims.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      used_q <= '0;
    end else begin
      for (int f = 0; f < NUM_ALU_FUS; f++) begin
        if (sel_valid[f]) used_q[sel_row[f]] <= 1'b0;
      end
      if (disp_fire) begin
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
          if (alloc_valid[k]) used_q[alloc_row[k]] <= 1'b1;
        end
      end
    end
  end

  // Payload: wakeup of stored sources and write of newly dispatched entries.
  // Wakeup touches used rows only, dispatch unused rows only.
  always_ff @(posedge clk_i) begin
    for (int r = 0; r < NUM_RS_ROWS; r++) begin
      if (used_q[r] && !rs1_rdy_q[r] && wake1[r][WORD_SIZE]) begin
        rs1_rdy_q[r] <= 1'b1;
        rs1_val_q[r] <= wake1[r][WORD_SIZE-1:0];
      end
      if (used_q[r] && !rs2_rdy_q[r] && wake2[r][WORD_SIZE]) begin
        rs2_rdy_q[r] <= 1'b1;
        rs2_val_q[r] <= wake2[r][WORD_SIZE-1:0];
      end
    end
    if (disp_fire) begin
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        if (alloc_valid[k]) begin
          contr_q[alloc_row[k]]   <= disp_contr_i[k*CONTR_SIG_SIZE +: CONTR_SIG_SIZE];
          alu_op_q[alloc_row[k]]  <= disp_alu_op_i[k*ALU_OP_SIZE +: ALU_OP_SIZE];
          dest_q[alloc_row[k]]    <= disp_dest_i[k*TAG +: TAG];
          rob_q[alloc_row[k]]     <= disp_rob_i[k*ROB_IDX_SIZE +: ROB_IDX_SIZE];
          rs1_tag_q[alloc_row[k]] <= disp_rs1_i[k*TAG +: TAG];
          rs2_tag_q[alloc_row[k]] <= disp_rs2_i[k*TAG +: TAG];
          imm_q[alloc_row[k]]     <= disp_imm_i[k*WORD_SIZE +: WORD_SIZE];
          rs1_rdy_q[alloc_row[k]] <= disp_rs1_ready_i[k] | byp1[k][WORD_SIZE];
          rs2_rdy_q[alloc_row[k]] <= disp_rs2_ready_i[k] | byp2[k][WORD_SIZE];
          rs1_val_q[alloc_row[k]] <= disp_rs1_ready_i[k] ?
                                     disp_rs1_val_i[k*WORD_SIZE +: WORD_SIZE] :
                                     byp1[k][WORD_SIZE-1:0];
          rs2_val_q[alloc_row[k]] <= disp_rs2_ready_i[k] ?
                                     disp_rs2_val_i[k*WORD_SIZE +: WORD_SIZE] :
                                     byp2[k][WORD_SIZE-1:0];
        end
      end
    end
  end

  // Issue registers: strobe for one cycle, payload holds when not selected.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      issue_valid_o  <= '0;
      issue_alu_op_o <= '0;
      issue_contr_o  <= '0;
      issue_dest_o   <= '0;
      issue_rob_o    <= '0;
      issue_data0_o  <= '0;
      issue_data1_o  <= '0;
    end else if (flush_i) begin
      issue_valid_o <= '0;
    end else begin
      issue_valid_o <= sel_valid;
      for (int f = 0; f < NUM_ALU_FUS; f++) begin
        if (sel_valid[f]) begin
          issue_alu_op_o[f*ALU_OP_SIZE +: ALU_OP_SIZE]       <= alu_op_q[sel_row[f]];
          issue_contr_o[f*CONTR_SIG_SIZE +: CONTR_SIG_SIZE]  <= contr_q[sel_row[f]];
          issue_dest_o[f*TAG +: TAG]                         <= dest_q[sel_row[f]];
          issue_rob_o[f*ROB_IDX_SIZE +: ROB_IDX_SIZE]        <= rob_q[sel_row[f]];
          issue_data0_o[f*WORD_SIZE +: WORD_SIZE]            <= rs1_val_q[sel_row[f]];
          issue_data1_o[f*WORD_SIZE +: WORD_SIZE]            <=
            contr_q[sel_row[f]][CONTR_ALUSRC_INDEX] ? imm_q[sel_row[f]] : rs2_val_q[sel_row[f]];
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed scenarios for reservation_station.
module tb_reservation_station;
  localparam int W  = 32;
  localparam int T  = 6;
  localparam int OP = 4;
  localparam int CS = 5;
  localparam int RB = 6;
  localparam int DW = 2;
  localparam int NF = 2;
  localparam int NC = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic [DW-1:0]  disp_valid = '0;
  logic           disp_ready;
  logic [DW*OP-1:0] disp_alu_op = '0;
  logic [DW*CS-1:0] disp_contr = '0;
  logic [DW*T-1:0]  disp_dest = '0;
  logic [DW*RB-1:0] disp_rob = '0;
  logic [DW*T-1:0]  disp_rs1 = '0;
  logic [DW*T-1:0]  disp_rs2 = '0;
  logic [DW*W-1:0]  disp_rs1_val = '0;
  logic [DW*W-1:0]  disp_rs2_val = '0;
  logic [DW-1:0]    disp_rs1_ready = '0;
  logic [DW-1:0]    disp_rs2_ready = '0;
  logic [DW*W-1:0]  disp_imm = '0;
  logic [NC-1:0]    cdb_valid = '0;
  logic [NC*T-1:0]  cdb_tag = '0;
  logic [NC*W-1:0]  cdb_data = '0;
  logic [NF-1:0]    fu_ready = '0;
  logic [NF-1:0]    issue_valid;
  logic [NF*OP-1:0] issue_alu_op;
  logic [NF*CS-1:0] issue_contr;
  logic [NF*T-1:0]  issue_dest;
  logic [NF*RB-1:0] issue_rob;
  logic [NF*W-1:0]  issue_data0;
  logic [NF*W-1:0]  issue_data1;
  logic [4:0]       free_count;

  int checks = 0;
  int failures = 0;

  reservation_station dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .disp_valid_i(disp_valid), .disp_ready_o(disp_ready),
    .disp_alu_op_i(disp_alu_op), .disp_contr_i(disp_contr),
    .disp_dest_i(disp_dest), .disp_rob_i(disp_rob),
    .disp_rs1_i(disp_rs1), .disp_rs2_i(disp_rs2),
    .disp_rs1_val_i(disp_rs1_val), .disp_rs2_val_i(disp_rs2_val),
    .disp_rs1_ready_i(disp_rs1_ready), .disp_rs2_ready_i(disp_rs2_ready),
    .disp_imm_i(disp_imm),
    .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
    .fu_ready_i(fu_ready),
    .issue_valid_o(issue_valid), .issue_alu_op_o(issue_alu_op),
    .issue_contr_o(issue_contr), .issue_dest_o(issue_dest),
    .issue_rob_o(issue_rob), .issue_data0_o(issue_data0),
    .issue_data1_o(issue_data1), .free_count_o(free_count)
  );

  // Clock
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_lane(input int k, input logic [OP-1:0] op, input logic [CS-1:0] contr,
                          input logic [RB-1:0] rob, input logic [T-1:0] t1, input logic [W-1:0] v1,
                          input logic r1, input logic [T-1:0] t2, input logic [W-1:0] v2,
                          input logic r2, input logic [W-1:0] imm);
    disp_valid[k]            = 1'b1;
    disp_alu_op[k*OP +: OP]  = op;
    disp_contr[k*CS +: CS]   = contr;
    disp_dest[k*T +: T]      = T'(rob);
    disp_rob[k*RB +: RB]     = rob;
    disp_rs1[k*T +: T]       = t1;
    disp_rs1_val[k*W +: W]   = v1;
    disp_rs1_ready[k]        = r1;
    disp_rs2[k*T +: T]       = t2;
    disp_rs2_val[k*W +: W]   = v2;
    disp_rs2_ready[k]        = r2;
    disp_imm[k*W +: W]       = imm;
  endtask

  task automatic clear_disp();
    disp_valid = '0;
    disp_rs1_ready = '0;
    disp_rs2_ready = '0;
  endtask

  task automatic set_cdb(input int c, input logic [T-1:0] tag, input logic [W-1:0] data);
    cdb_valid[c]       = 1'b1;
    cdb_tag[c*T +: T]  = tag;
    cdb_data[c*W +: W] = data;
  endtask

  // Four unready rows then one ready row (rows 0..4).
  task automatic fill_five();
    set_lane(0, 4'd1, 5'd0, 6'd0, 6'd50, 32'd0, 1'b0, 6'd1, 32'd1, 1'b1, 32'd0);
    set_lane(1, 4'd1, 5'd0, 6'd1, 6'd51, 32'd0, 1'b0, 6'd1, 32'd1, 1'b1, 32'd0);
    step();
    set_lane(0, 4'd1, 5'd0, 6'd2, 6'd52, 32'd0, 1'b0, 6'd1, 32'd1, 1'b1, 32'd0);
    set_lane(1, 4'd1, 5'd0, 6'd3, 6'd53, 32'd0, 1'b0, 6'd1, 32'd1, 1'b1, 32'd0);
    step();
    clear_disp();
    set_lane(0, 4'd1, 5'd0, 6'd4, 6'd1, 32'd44, 1'b1, 6'd1, 32'd1, 1'b1, 32'd0);
    step();
    clear_disp();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    if (disp_ready !== 1'b0) begin
      $display("FAIL reset_disp_ready got=%b exp=0", disp_ready); failures++;
    end
    checks++;
    step();
    if (issue_valid !== 2'b00) begin
      $display("FAIL reset_issue_valid got=%b exp=00", issue_valid); failures++;
    end
    checks++;
    if (free_count !== 5'd16) begin
      $display("FAIL reset_free_count got=%0d exp=16", free_count); failures++;
    end
    checks++;
    if (issue_data0 !== '0 || issue_data1 !== '0 || issue_rob !== '0) begin
      $display("FAIL reset_issue_data got=%h/%h exp=0", issue_data0, issue_data1); failures++;
    end
    checks++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ready_dispatch();
    fu_ready = 2'b11;
    set_lane(0, 4'd1, 5'd0, 6'd10, 6'd1, 32'd5, 1'b1, 6'd2, 32'd7, 1'b1, 32'd0);
    set_lane(1, 4'd2, 5'd0, 6'd11, 6'd3, 32'd9, 1'b1, 6'd4, 32'd4, 1'b1, 32'd0);
    if (disp_ready !== 1'b1) begin
      $display("FAIL ready_disp_ready got=%b exp=1", disp_ready); failures++;
    end
    checks++;
    step();
    clear_disp();
    if (free_count !== 5'd14 || issue_valid !== 2'b00) begin
      $display("FAIL ready_after_disp free=%0d valid=%b exp free=14 valid=00", free_count, issue_valid);
      failures++;
    end
    checks++;
    step();
    if (issue_valid !== 2'b11) begin
      $display("FAIL ready_issue_valid got=%b exp=11", issue_valid); failures++;
    end
    checks++;
    if (issue_data0 !== {32'd9, 32'd5} || issue_data1 !== {32'd4, 32'd7}) begin
      $display("FAIL ready_issue_data d0=%h d1=%h exp d0=%h d1=%h", issue_data0, issue_data1,
               {32'd9, 32'd5}, {32'd4, 32'd7}); failures++;
    end
    checks++;
    if (issue_rob !== {6'd11, 6'd10} || issue_alu_op !== {4'd2, 4'd1}) begin
      $display("FAIL ready_issue_fields rob=%h op=%h exp rob=%h op=21", issue_rob, issue_alu_op,
               {6'd11, 6'd10}); failures++;
    end
    checks++;
    if (free_count !== 5'd16) begin
      $display("FAIL ready_free_return got=%0d exp=16", free_count); failures++;
    end
    checks++;
    step();
    if (issue_valid !== 2'b00) begin
      $display("FAIL ready_strobe_once got=%b exp=00", issue_valid); failures++;
    end
    checks++;
  endtask

  task automatic test_cdb_wakeup();
    fu_ready = 2'b11;
    set_lane(0, 4'd3, 5'd0, 6'd20, 6'd12, 32'd0, 1'b0, 6'd5, 32'd3, 1'b1, 32'd0);
    step();
    clear_disp();
    step();
    if (issue_valid !== 2'b00) begin
      $display("FAIL wake_wait got=%b exp=00", issue_valid); failures++;
    end
    checks++;
    set_cdb(0, 6'd12, 32'h0000ABCD);
    step();
    cdb_valid = '0;
    if (issue_valid !== 2'b00) begin
      $display("FAIL wake_no_same_cycle got=%b exp=00", issue_valid); failures++;
    end
    checks++;
    step();
    if (issue_valid !== 2'b01 || issue_data0[31:0] !== 32'h0000ABCD || issue_data1[31:0] !== 32'd3) begin
      $display("FAIL wake_issue valid=%b d0=%h d1=%h exp valid=01 d0=0000abcd d1=3",
               issue_valid, issue_data0[31:0], issue_data1[31:0]); failures++;
    end
    checks++;
    step();
  endtask

  task automatic test_bypass();
    fu_ready = 2'b11;
    set_lane(0, 4'd4, 5'd0, 6'd21, 6'd1, 32'd1, 1'b1, 6'd7, 32'd0, 1'b0, 32'd0);
    set_cdb(0, 6'd7, 32'h77);
    set_cdb(1, 6'd7, 32'h88);
    step();
    clear_disp();
    cdb_valid = '0;
    if (issue_valid !== 2'b00) begin
      $display("FAIL bypass_latency got=%b exp=00", issue_valid); failures++;
    end
    checks++;
    step();
    if (issue_valid !== 2'b01 || issue_data1[31:0] !== 32'h77 || issue_rob[5:0] !== 6'd21) begin
      $display("FAIL bypass_issue valid=%b d1=%h rob=%0d exp valid=01 d1=77 rob=21",
               issue_valid, issue_data1[31:0], issue_rob[5:0]); failures++;
    end
    checks++;
    step();
  endtask

  task automatic test_full();
    fu_ready = 2'b01;
    for (int i = 0; i < 8; i++) begin
      set_lane(0, 4'd5, 5'd0, 6'(2*i), 6'(16 + 2*i), 32'd0, 1'b0, 6'd1, 32'd1, 1'b1, 32'd0);
      set_lane(1, 4'd5, 5'd0, 6'(2*i+1), 6'(17 + 2*i), 32'd0, 1'b0, 6'd1, 32'd1, 1'b1, 32'd0);
      if (i == 7 && (disp_ready !== 1'b1 || free_count !== 5'd2)) begin
        $display("FAIL full_at_two ready=%b free=%0d exp ready=1 free=2", disp_ready, free_count);
        failures++;
      end
      if (i == 7) checks++;
      step();
    end
    clear_disp();
    set_lane(0, 4'd5, 5'd0, 6'd40, 6'd60, 32'd0, 1'b0, 6'd1, 32'd1, 1'b1, 32'd0);
    if (free_count !== 5'd0 || disp_ready !== 1'b0) begin
      $display("FAIL full_at_zero free=%0d ready=%b exp free=0 ready=0", free_count, disp_ready);
      failures++;
    end
    checks++;
    set_cdb(0, 6'd16, 32'h16);
    step();
    cdb_valid = '0;
    step();
    if (issue_valid !== 2'b01 || issue_rob[5:0] !== 6'd0) begin
      $display("FAIL full_release_issue valid=%b rob=%0d exp valid=01 rob=0", issue_valid, issue_rob[5:0]);
      failures++;
    end
    checks++;
    if (free_count !== 5'd1 || disp_ready !== 1'b0) begin
      $display("FAIL full_at_one free=%0d ready=%b exp free=1 ready=0", free_count, disp_ready);
      failures++;
    end
    checks++;
    step();
    if (free_count !== 5'd1) begin
      $display("FAIL full_no_partial_dispatch free=%0d exp=1", free_count); failures++;
    end
    checks++;
    clear_disp();
    set_cdb(1, 6'd17, 32'h17);
    step();
    cdb_valid = '0;
    step();
    if (free_count !== 5'd2 || disp_ready !== 1'b1) begin
      $display("FAIL full_reopen free=%0d ready=%b exp free=2 ready=1", free_count, disp_ready);
      failures++;
    end
    checks++;
    flush = 1'b1;
    step();
    flush = 1'b0;
    if (free_count !== 5'd16) begin
      $display("FAIL full_flush_clear free=%0d exp=16", free_count); failures++;
    end
    checks++;
  endtask

  task automatic test_select_priority();
    fu_ready = 2'b00;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 2; k++) begin
        int n;
        logic rdy;
        n = 2*i + k;
        rdy = (n == 1 || n == 4 || n == 9);
        set_lane(k, 4'(n), (n == 9) ? 5'b00100 : 5'b00000, 6'(n), rdy ? 6'd1 : 6'(40 + n),
                 32'(32'h100 + n), rdy, 6'd2, 32'(32'h200 + n), 1'b1, 32'h1234);
      end
      step();
    end
    clear_disp();
    fu_ready = 2'b01;
    step();
    if (issue_valid !== 2'b01 || issue_rob[5:0] !== 6'd1 || issue_data0[31:0] !== 32'h101) begin
      $display("FAIL sel_fu0_first valid=%b rob=%0d d0=%h exp valid=01 rob=1 d0=101",
               issue_valid, issue_rob[5:0], issue_data0[31:0]); failures++;
    end
    checks++;
    fu_ready = 2'b11;
    step();
    if (issue_valid !== 2'b11 || issue_rob !== {6'd9, 6'd4}) begin
      $display("FAIL sel_two_fus valid=%b rob=%h exp valid=11 rob=%h", issue_valid, issue_rob, {6'd9, 6'd4});
      failures++;
    end
    checks++;
    if (issue_data1[63:32] !== 32'h1234 || issue_data1[31:0] !== 32'h204) begin
      $display("FAIL sel_alusrc d1=%h exp=00001234_00000204", issue_data1); failures++;
    end
    checks++;
    if (free_count !== 5'd9) begin
      $display("FAIL sel_free free=%0d exp=9", free_count); failures++;
    end
    checks++;
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_flush_and_reset();
    fu_ready = 2'b11;
    fill_five();
    if (free_count !== 5'd11) begin
      $display("FAIL flush_pre free=%0d exp=11", free_count); failures++;
    end
    checks++;
    flush = 1'b1;
    set_lane(0, 4'd6, 5'd0, 6'd30, 6'd1, 32'd1, 1'b1, 6'd1, 32'd1, 1'b1, 32'd0);
    set_lane(1, 4'd6, 5'd0, 6'd31, 6'd1, 32'd1, 1'b1, 6'd1, 32'd1, 1'b1, 32'd0);
    step();
    flush = 1'b0;
    clear_disp();
    if (free_count !== 5'd16 || issue_valid !== 2'b00) begin
      $display("FAIL flush_clear free=%0d valid=%b exp free=16 valid=00", free_count, issue_valid);
      failures++;
    end
    checks++;
    step();
    if (issue_valid !== 2'b00 || free_count !== 5'd16) begin
      $display("FAIL flush_dropped valid=%b free=%0d exp valid=00 free=16", issue_valid, free_count);
      failures++;
    end
    checks++;
    fill_five();
    rst_n = 1'b0;
    set_lane(0, 4'd6, 5'd0, 6'd30, 6'd1, 32'd1, 1'b1, 6'd1, 32'd1, 1'b1, 32'd0);
    set_lane(1, 4'd6, 5'd0, 6'd31, 6'd1, 32'd1, 1'b1, 6'd1, 32'd1, 1'b1, 32'd0);
    step();
    clear_disp();
    if (free_count !== 5'd16 || issue_valid !== 2'b00 || issue_data0 !== '0) begin
      $display("FAIL rst_clear free=%0d valid=%b d0=%h exp free=16 valid=00 d0=0",
               free_count, issue_valid, issue_data0); failures++;
    end
    checks++;
    rst_n = 1'b1;
    step();
    if (issue_valid !== 2'b00 || free_count !== 5'd16) begin
      $display("FAIL rst_dropped valid=%b free=%0d exp valid=00 free=16", issue_valid, free_count);
      failures++;
    end
    checks++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_ready_dispatch();
    test_cdb_wakeup();
    test_bypass();
    test_full();
    test_select_priority();
    test_flush_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
# reservation_station

Parametrised unified reservation station for the out-of-order core, sitting between rename/dispatch and the ALU functional units. It accepts up to DISPATCH_WIDTH renamed instructions per cycle and holds them until both source operands are ready. Operands are woken by NUM_CDB common-data-bus broadcasts. Up to NUM_ALU_FUS ready instructions per cycle are selected and issued to free ALUs with registered operand outputs.

## Interface
Parameters:
- WORD_SIZE, 32, datapath width
- NUM_P_REGS, 64, physical registers; TAG = $clog2(NUM_P_REGS)
- ALU_OP_SIZE, 4, ALU opcode width
- CONTR_SIG_SIZE, 5, control bundle width
- CONTR_ALUSRC_INDEX, 2, control bit selecting imm as operand 1
- NUM_RS_ROWS, 16, entries (≥ DISPATCH_WIDTH)
- DISPATCH_WIDTH, 2, dispatch lanes
- NUM_ALU_FUS, 2, issue ports
- NUM_CDB, 2, wakeup buses
- ROB_IDX_SIZE, 6, ROB index width

Ports (per-lane/per-port fields flattened, lane k at [k*W +: W]):
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- flush_i  in  1  synchronous clear of all entries
- disp_valid_i  in  DISPATCH_WIDTH  lane valid
- disp_ready_o  out  1  all lanes accepted this cycle
- disp_alu_op_i / disp_contr_i / disp_dest_i / disp_rob_i  in  per lane  op, control, dest tag, ROB index
- disp_rs1_i, disp_rs2_i  in  TAG per lane  source tags
- disp_rs1_val_i, disp_rs2_val_i  in  WORD_SIZE per lane  source values (valid when ready)
- disp_rs1_ready_i, disp_rs2_ready_i  in  1 per lane  scoreboard readiness
- disp_imm_i  in  WORD_SIZE per lane  immediate
- cdb_valid_i  in  NUM_CDB;  cdb_tag_i  in  TAG each;  cdb_data_i  in  WORD_SIZE each
- fu_ready_i  in  NUM_ALU_FUS  FU can accept next cycle
- issue_valid_o  out  NUM_ALU_FUS  one-cycle issue strobe per FU
- issue_alu_op_o / issue_contr_o / issue_dest_o / issue_rob_o  out  per FU
- issue_data0_o, issue_data1_o  out  WORD_SIZE per FU  operands
- free_count_o  out  $clog2(NUM_RS_ROWS+1)  free entries (registered state)

## Operation
- Entry: use, contr, alu_op, dest, rob, rs1/rs2 tag, value, ready, imm.
- disp_ready_o = rst_n_i & free_count_o ≥ DISPATCH_WIDTH (all-or-nothing). Dispatch fires when disp_ready_o && |disp_valid_i. Each valid lane takes the next lowest-index free row, in lane order; invalid lanes consume nothing.
- Dispatch-time bypass: if a source is not ready and its tag matches a valid CDB in the same cycle, the entry is written ready with cdb_data.
- Wakeup: every used, not-ready source matching a valid cdb_tag_i captures cdb_data_i and sets ready at the edge. On duplicate tags, the lowest CDB index wins.
- Select (combinational on registered state): FUs are visited 0..NUM_ALU_FUS-1. FU f with fu_ready_i[f]=1 takes the lowest-index used row with both sources ready that was not taken by a lower FU.
- Issue: at the edge, the selected row's use bit clears and the issue_* registers load. data0 = rs1_val. data1 = imm if contr[CONTR_ALUSRC_INDEX] else rs2_val. issue_valid_o[f] is high for exactly that one cycle. FUs without a selection drive issue_valid_o=0; their data holds its last value.
- No backpressure after issue. The FU must honour its own fu_ready_i.
- Flush or reset: all use bits and issue_valid_o cleared, dispatch ignored that cycle. Flush has priority over dispatch, wakeup and issue.

## Timing
- Reset values: issue_valid_o=0; all issue data/fields 0; free_count_o=NUM_RS_ROWS; disp_ready_o=0 while rst_n_i low.
- Dispatch at edge E means the entry is selectable in cycle E+1, so issue_valid_o rises at edge E+1 at the earliest (minimum 1-cycle RS latency).
- CDB wakeup at edge E means the entry is selectable from cycle E+1. There is no same-cycle wakeup-select.
- A row freed by issue at edge E is counted free and allocatable from cycle E+1. There is no same-cycle free-and-reuse.
- Full: free_count_o < DISPATCH_WIDTH drops disp_ready_o even if fewer lanes are valid.
- Simultaneous dispatch, wakeup and issue in one cycle are independent, because they touch disjoint rows.

## Test plan
- Reset, then dispatch 2 entries with all sources ready (add 5+7, sub 9-4), fu_ready_i=11 → next cycle issue_valid_o=11, data 5/7 and 9/4, free_count_o returns to 16.
- Dispatch rs1 tag 12 not ready; two cycles later CDB tag 12 data 0xABCD → issue one cycle after the CDB, data0=0xABCD.
- CDB tag 7 in the same cycle as dispatching a source with tag 7 not ready → entry ready at write, issued next cycle.
- Fill 16 rows with unready sources → disp_ready_o=0 at free_count_o=0 and at free=1. Release one tag, issue one row → disp_ready_o stays 0 until free=2.
- Three ready rows (1,4,9), fu_ready_i=01 → row 1 issues on FU0. Next cycle fu_ready_i=11 → row 4 to FU0, row 9 to FU1. ALUSRC set → data1=imm.
- Flush with 5 used rows while dispatching → next cycle free_count_o=16, issue_valid_o=0, dispatched lanes dropped. Repeat with rst_n_i low for the same result.
